// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
//
// Frequency-sweep sequencer for the NCO step input. On start it loads a first
// tuning word, then after each dwell adds a fixed increment, for a programmed
// number of steps, and pulses o_done at the end of the pass. Increments
// saturate at the all-ones tuning word and raise the sticky o_sat flag.
//
// Build option:
//   NCO_SWEEP_LOOP_EN  when defined, a finished pass restarts at the latched
//                      start word instead of returning to idle; the sweep then
//                      repeats until abort or reset.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_start      start request (accepted only in idle, and only without abort)
//   i_abort      abort request (wins over start; stops a running sweep)
//   i_f_start    first tuning word
//   i_f_step     unsigned increment per step
//   i_n_steps    number of increments (n_steps+1 frequencies visited)
//   i_dwell      cycles per frequency, 0 treated as 1
//   o_freq_step  tuning word to the NCO
//   o_busy       sweep in progress
//   o_step_stb   one-cycle pulse when a new o_freq_step value first appears
//   o_done       one-cycle pulse at the end of a pass
//   o_sat        sticky saturation flag for the current sweep
// -----------------------------------------------------------------------------
module nco_sweep_ctrl #(
  parameter int FW = 10,
  parameter int NW = 8,
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [FW-1:0] i_f_start,
  input  logic [FW-1:0] i_f_step,
  input  logic [NW-1:0] i_n_steps,
  input  logic [DW-1:0] i_dwell,
  output logic [FW-1:0] o_freq_step,
  output logic          o_busy,
  output logic          o_step_stb,
  output logic          o_done,
  output logic          o_sat
);

  localparam logic [DW-1:0] DW_ONE = DW'(1);
  localparam logic [NW-1:0] NW_ONE = NW'(1);

  typedef enum logic {ST_IDLE, ST_DWELL} state_t;

  state_t        state_reg,  state_next;
  logic [FW-1:0] freq_reg,   freq_next;
  logic [FW-1:0] step_reg,   step_next;
  logic [NW-1:0] k_reg,      k_next;
  logic [NW-1:0] nsteps_reg, nsteps_next;
  logic [DW-1:0] cnt_reg,    cnt_next;
  logic [DW-1:0] dwell_reg,  dwell_next;
  logic          busy_reg,   busy_next;
  logic          stb_reg,    stb_next;
  logic          done_reg,   done_next;
  logic          sat_reg,    sat_next;
`ifdef NCO_SWEEP_LOOP_EN
  logic [FW-1:0] fstart_reg, fstart_next;
`endif

  // One extra bit catches the carry-out; on carry every result bit is forced
  // high, which is exactly the saturated all-ones word.
  logic [FW:0]   sum;
  logic [FW-1:0] sum_sat;
  logic          dwell_end;

  assign sum = {1'b0, freq_reg} + {1'b0, step_reg};

  generate
    for (genvar gi = 0; gi < FW; gi++) begin : g_sat
      assign sum_sat[gi] = sum[gi] | sum[FW];
    end
  endgenerate

  // dwell_reg is never 0 while sweeping (0 is mapped to 1 at start).
  assign dwell_end = (cnt_reg == (dwell_reg - DW_ONE));

  always_comb begin
    state_next  = state_reg;
    freq_next   = freq_reg;
    step_next   = step_reg;
    k_next      = k_reg;
    nsteps_next = nsteps_reg;
    cnt_next    = cnt_reg;
    dwell_next  = dwell_reg;
    busy_next   = busy_reg;
    sat_next    = sat_reg;
    stb_next    = 1'b0;
    done_next   = 1'b0;
`ifdef NCO_SWEEP_LOOP_EN
    fstart_next = fstart_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          step_next   = i_f_step;
          nsteps_next = i_n_steps;
          dwell_next  = (i_dwell == '0) ? DW_ONE : i_dwell;
          freq_next   = i_f_start;
`ifdef NCO_SWEEP_LOOP_EN
          fstart_next = i_f_start;
`endif
          k_next      = '0;
          cnt_next    = '0;
          sat_next    = 1'b0;
          busy_next   = 1'b1;
          stb_next    = 1'b1;
          state_next  = ST_DWELL;
        end
      end

      ST_DWELL: begin
        // Abort takes priority over a step or pass end in the same cycle.
        if (i_abort) begin
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (dwell_end) begin
          cnt_next = '0;
          if (k_reg != nsteps_reg) begin
            freq_next = sum_sat;
            sat_next  = sat_reg | sum[FW];
            k_next    = k_reg + NW_ONE;
            stb_next  = 1'b1;
          end else begin
            done_next = 1'b1;
`ifdef NCO_SWEEP_LOOP_EN
            freq_next = fstart_reg;
            k_next    = '0;
            sat_next  = 1'b0;
            stb_next  = 1'b1;
`else
            busy_next  = 1'b0;
            state_next = ST_IDLE;
`endif
          end
        end else begin
          cnt_next = cnt_reg + DW_ONE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      freq_reg   <= '0;
      step_reg   <= '0;
      k_reg      <= '0;
      nsteps_reg <= '0;
      cnt_reg    <= '0;
      dwell_reg  <= '0;
      busy_reg   <= 1'b0;
      stb_reg    <= 1'b0;
      done_reg   <= 1'b0;
      sat_reg    <= 1'b0;
`ifdef NCO_SWEEP_LOOP_EN
      fstart_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      freq_reg   <= freq_next;
      step_reg   <= step_next;
      k_reg      <= k_next;
      nsteps_reg <= nsteps_next;
      cnt_reg    <= cnt_next;
      dwell_reg  <= dwell_next;
      busy_reg   <= busy_next;
      stb_reg    <= stb_next;
      done_reg   <= done_next;
      sat_reg    <= sat_next;
`ifdef NCO_SWEEP_LOOP_EN
      fstart_reg <= fstart_next;
`endif
    end
  end

  assign o_freq_step = freq_reg;
  assign o_busy      = busy_reg;
  assign o_step_stb  = stb_reg;
  assign o_done      = done_reg;
  assign o_sat       = sat_reg;

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep sequencer that drives the frequency-step input of the NCO. It steps the tuning word from a start value by a fixed increment after a programmable dwell, for a programmed number of steps. It then signals completion, so the NCO's sine output sweeps across a band without software or testbench intervention. It sits between the board-level switch/key logic and the NCO `SW` frequency input.

## Interface
Parameters:
- `FW`, 10, frequency tuning word width (matches NCO step input).
- `NW`, 8, step-count width.
- `DW`, 24, dwell counter width.

Ports:
- `i_clk`  input  1  system clock (50 MHz on board).
- `i_rst`  input  1  reset; synchronous, active-high.
- `i_start`  input  1  start request; sampled every cycle.
- `i_abort`  input  1  abort request; sampled every cycle.
- `i_f_start`  input  FW  first tuning word of the sweep.
- `i_f_step`  input  FW  increment added per step (unsigned).
- `i_n_steps`  input  NW  number of increments; the sweep visits `i_n_steps`+1 frequencies.
- `i_dwell`  input  DW  cycles spent at each frequency; 0 treated as 1.
- `o_freq_step`  output  FW  tuning word to the NCO.
- `o_busy`  output  1  sweep in progress.
- `o_step_stb`  output  1  one-cycle pulse on the cycle a new `o_freq_step` value first appears.
- `o_done`  output  1  one-cycle pulse when a sweep pass completes.
- `o_sat`  output  1  sticky; set when an increment saturated during the current sweep.

## Operation
- FSM states: IDLE, DWELL.
- IDLE:
  - `i_start`=1 and `i_abort`=0 latches `i_f_start`, `i_f_step`, `i_n_steps` and `i_dwell` (0→1).
  - Loads `o_freq_step`←`i_f_start`, step index k←0, dwell counter←0, `o_sat`←0, then goes to DWELL.
  - Inputs are not re-sampled until the next start.
- DWELL:
  - The dwell counter increments each cycle.
  - When the counter reaches dwell−1 and k<n_steps: `o_freq_step`←`o_freq_step`+f_step, k←k+1, counter←0, stay in DWELL.
  - When the counter reaches dwell−1 and k=n_steps: the pass ends (see Configuration).
- Arithmetic: the sum is computed at FW+1 bits. On carry-out, `o_freq_step` saturates at 2^FW−1 and `o_sat`←1. Further steps stay at 2^FW−1.
- `i_start` during DWELL is ignored.
- `i_abort` in DWELL: next state IDLE; `o_freq_step` holds its value; no `o_done`; `o_busy`←0.
- `i_start` and `i_abort` in the same cycle: abort wins and the start is dropped.
- `i_n_steps`=0: a single dwell at `i_f_start`, then done.
- Reset in any state: IDLE, all outputs 0, counters 0.

## Timing
- All outputs are registered.
- Reset values: `o_freq_step`=0, `o_busy`=0, `o_step_stb`=0, `o_done`=0, `o_sat`=0.
- Start accepted at cycle T:
  - At T+1: `o_busy`=1, `o_freq_step`=f_start, `o_step_stb`=1.
- Each frequency is held for exactly `dwell` cycles. The next value and its `o_step_stb` appear at T+1+j·dwell for j=1..n_steps.
- Final dwell ends at E=T+(n_steps+1)·dwell:
  - At E+1: `o_done`=1 for one cycle.
  - At E+1: `o_busy`=0, unless loop mode is enabled.
- Earliest restart: `i_start` at E+1 is accepted, since the FSM is in IDLE that cycle.
- Abort at cycle A: `o_busy`=0 at A+1; no strobe or done at A+1.
- `o_sat` changes on the same cycle as the saturated `o_freq_step` value.

## Configuration
- `NCO_SWEEP_LOOP_EN` defined:
  - At pass end, `o_freq_step`←latched f_start, k←0, `o_sat`←0, and the FSM stays in DWELL.
  - `o_done` and `o_step_stb` both pulse at E+1; `o_busy` stays 1.
  - The sweep repeats until `i_abort` or reset.
- `NCO_SWEEP_LOOP_EN` not defined:
  - At pass end the FSM returns to IDLE; `o_freq_step` holds the last value and `o_busy` drops at E+1.

## Test plan
- Reset then idle. Hold `i_rst`=1 for 3 cycles, release, drive no start → all outputs 0 for 20 cycles.
- Basic sweep. f_start=64, f_step=50, n_steps=14, dwell=10, pulse start → `o_freq_step` shows 64,114,…,764, each held exactly 10 cycles. 15 `o_step_stb` pulses, a single `o_done` 150 cycles after the first value, `o_busy` low afterwards, `o_freq_step` stays 764.
- Saturation. f_start=1000, f_step=50, n_steps=3, dwell=4 → values 1000,1023,1023,1023; `o_sat`=1 from the second value onward; `o_done` pulses once.
- Edge parameters. n_steps=0, dwell=0, f_start=5 → `o_freq_step`=5 for 1 cycle, `o_done` on the next cycle, `o_busy` high for exactly 1 cycle.
- Abort and collisions:
  - Abort mid-sweep at step 3 → `o_busy` 0 next cycle, `o_freq_step` holds, no `o_done`.
  - `i_start` and `i_abort` asserted together in IDLE → no sweep starts.
  - `i_start` pulsed during DWELL → no effect on sequence timing.
- Loop build (`NCO_SWEEP_LOOP_EN` defined). f_start=10, f_step=1, n_steps=2, dwell=3 → sequence 10,11,12,10,11,12…; `o_done` pulses every 9 cycles; `o_busy` stays high until abort.
